// File: rtl/riscv_32i_defs_pkg.sv
// rtl/riscv_32i_defs_pkg.sv - shared RV32I core definitions
package riscv_32i_defs_pkg;

    // Architectural register / data word width
    localparam int XLEN = 32;

endpackage : riscv_32i_defs_pkg

// File: rtl/lut_ram.sv
// rtl/lut_ram.sv - distributed LUT RAM, sync write, async read, async clear
module lut_ram
    import riscv_32i_defs_pkg::*;
#(
    parameter int  LUT_WIDTH = XLEN,
    parameter int  LUT_DEPTH = 256,
    localparam int AW        = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [LUT_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [LUT_WIDTH-1:0] rd_data
);

    // Depth widened by one bit so the range check also works when
    // LUT_DEPTH is an exact power of two (every address is then in range).
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(LUT_DEPTH);

    logic [LUT_WIDTH-1:0] mem_q [LUT_DEPTH];
    logic [LUT_WIDTH-1:0] mem_d [LUT_DEPTH];
    logic                 wr_hit;

    // A write only lands when enabled and aimed at a word that exists
    always_comb begin
        wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    end

    // Next contents: hold everything, replace the addressed word on a hit
    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage; reset wipes all words and overrides a coincident write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read from registered contents, so a same-address
    // write is only visible after its edge; missing words read as zero
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < DEPTH_W) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule : lut_ram

// File: tb/tb_lut_ram.sv
// tb/tb_lut_ram.sv - self-checking bench for lut_ram
interface lut_ram_intf #(
    parameter int LUT_WIDTH = 32,
    parameter int LUT_DEPTH = 256
) (
    input logic clk
);
    localparam int AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    logic                 rst_n;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [LUT_WIDTH-1:0] wr_data;
    logic [AW-1:0]        rd_addr;
    logic [LUT_WIDTH-1:0] rd_data;
endinterface : lut_ram_intf

module tb_lut_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    lut_ram_intf #(.LUT_WIDTH(32), .LUT_DEPTH(256)) bus  (.clk(clk));
    lut_ram_intf #(.LUT_WIDTH(8),  .LUT_DEPTH(12))  bus2 (.clk(clk));

    lut_ram #(.LUT_WIDTH(32), .LUT_DEPTH(256)) dut (
        .clk     (clk),
        .rst_n   (bus.rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

    lut_ram #(.LUT_WIDTH(8), .LUT_DEPTH(12)) dut2 (
        .clk     (clk),
        .rst_n   (bus2.rst_n),
        .wr_en   (bus2.wr_en),
        .wr_addr (bus2.wr_addr),
        .wr_data (bus2.wr_data),
        .rd_addr (bus2.rd_addr),
        .rd_data (bus2.rd_data)
    );

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [7:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] mdl [256];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 256; i++) mdl[i] = '0;
    endtask

    // Drive one access at the falling edge so it is stable before the next rising edge
    task automatic drive(input logic we, input logic [7:0] wa, input logic [31:0] wd, input logic [7:0] ra);
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_addr = ra;
        #1;
    endtask

    // Let the rising edge happen, update the model, settle
    task automatic edge_commit();
        @(posedge clk);
        if (bus.rst_n && bus.wr_en) mdl[bus.wr_addr] = bus.wr_data;
        #1;
    endtask

    task automatic drive2(input logic we, input logic [3:0] wa, input logic [7:0] wd, input logic [3:0] ra);
        @(negedge clk);
        bus2.wr_en   = we;
        bus2.wr_addr = wa;
        bus2.wr_data = wd;
        bus2.rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'd3,   32'h1234_5678, 8'd3,   32'h1234_5678};
        tbl[1] = '{1'b1, 8'd4,   32'hFFFF_FFFF, 8'd3,   32'h1234_5678};
        tbl[2] = '{1'b0, 8'd3,   32'h0000_0000, 8'd3,   32'h1234_5678};
        tbl[3] = '{1'b0, 8'd4,   32'h0000_0000, 8'd4,   32'hFFFF_FFFF};
        tbl[4] = '{1'b1, 8'd0,   32'h8000_0001, 8'd0,   32'h8000_0001};
        tbl[5] = '{1'b1, 8'd255, 32'hCAFE_F00D, 8'd255, 32'hCAFE_F00D};
        tbl[6] = '{1'b1, 8'd4,   32'h0000_0000, 8'd4,   32'h0000_0000};
        tbl[7] = '{1'b0, 8'd0,   32'hDEAD_BEEF, 8'd10,  32'h0000_0001};
        tbl[8] = '{1'b0, 8'd0,   32'h0000_0000, 8'd5,   32'h0000_0022};

        bus.rst_n  = 1'b0; bus.wr_en  = 1'b1; bus.wr_addr  = 8'd1; bus.wr_data  = 32'hFFFF_FFFF; bus.rd_addr  = 8'd1;
        bus2.rst_n = 1'b0; bus2.wr_en = 1'b0; bus2.wr_addr = 4'd0; bus2.wr_data = 8'h00;         bus2.rd_addr = 4'd0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_rd1", bus.rd_data, 32'h0);

        // Reset release and readback of cleared words
        drive(1'b0, 8'd0, 32'h0, 8'd0);
        bus.rst_n  = 1'b1;
        bus2.rst_n = 1'b1;
        #1;
        check("reset_rd0", bus.rd_data, 32'h0);
        bus.rd_addr = 8'd1;   #1; check("reset_rd1", bus.rd_data, 32'h0);
        bus.rd_addr = 8'd255; #1; check("reset_rd255", bus.rd_data, 32'h0);

        // First enabled edge after reset writes; visible with no extra cycle
        drive(1'b1, 8'd10, 32'h0000_0001, 8'd10);
        check("wr10_before", bus.rd_data, 32'h0);
        edge_commit();
        check("wr10_after", bus.rd_data, 32'h0000_0001);

        // Disabled write
        drive(1'b0, 8'd20, 32'hDEAD_BEEF, 8'd20);
        edge_commit();
        check("disabled_wr20", bus.rd_data, 32'h0);

        // Same-address collision
        drive(1'b1, 8'd5, 32'h11, 8'd5);
        edge_commit();
        drive(1'b1, 8'd5, 32'h22, 8'd5);
        check("collide_before", bus.rd_data, 32'h11);
        edge_commit();
        check("collide_after", bus.rd_data, 32'h22);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra);
            edge_commit();
            check($sformatf("tbl%0d", i), bus.rd_data, tbl[i].exp);
        end

        // Sweep with alternating write enable
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) == 0, 8'(i * 10), 32'(i + 1), 8'(i * 10));
            check($sformatf("sweep%0d_pre", i), bus.rd_data, mdl[i * 10]);
            edge_commit();
            check($sformatf("sweep%0d_post", i), bus.rd_data, mdl[i * 10]);
        end

        // Randomized traffic against the array model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] wa, ra;
            wa = 8'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom, ra);
            check("rand_pre", bus.rd_data, mdl[ra]);
            edge_commit();
            check("rand_post", bus.rd_data, mdl[ra]);
        end

        // Mid-run reset clears immediately, without a clock edge
        drive(1'b1, 8'd255, 32'hA5A5_A5A5, 8'd255);
        edge_commit();
        check("a5_written", bus.rd_data, 32'hA5A5_A5A5);
        @(negedge clk);
        #2;
        bus.rst_n = 1'b0;
        mdl_clear();
        #1;
        check("midreset_rd255", bus.rd_data, 32'h0);
        // Writes blocked across an edge while reset is held
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd7;
        bus.wr_data = 32'h7777_7777;
        bus.rd_addr = 8'd7;
        @(posedge clk);
        #1;
        check("reset_blocks_wr", bus.rd_data, 32'h0);
        drive(1'b0, 8'd7, 32'h0, 8'd3);
        bus.rst_n = 1'b1;
        #1;
        check("postreset_rd3", bus.rd_data, 32'h0);
        drive(1'b1, 8'd7, 32'h0BAD_CAFE, 8'd7);
        edge_commit();
        check("postreset_wr7", bus.rd_data, 32'h0BAD_CAFE);
        drive(1'b0, 8'd0, 32'h0, 8'd0);

        // Non-power-of-two depth: top word and out-of-range accesses
        drive2(1'b1, 4'd11, 8'h5A, 4'd11);
        check("np2_wr11", {24'h0, bus2.rd_data}, 32'h5A);
        drive2(1'b1, 4'd13, 8'hFF, 4'd13);
        check("np2_rd13", {24'h0, bus2.rd_data}, 32'h0);
        drive2(1'b1, 4'd15, 8'hC3, 4'd15);
        check("np2_rd15", {24'h0, bus2.rd_data}, 32'h0);
        drive2(1'b0, 4'd0, 8'h00, 4'd11);
        check("np2_keep11", {24'h0, bus2.rd_data}, 32'h5A);
        drive2(1'b1, 4'd0, 8'h3C, 4'd0);
        check("np2_wr0", {24'h0, bus2.rd_data}, 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_lut_ram
